// File: rtl/multi_pulse_sync_rx.sv
// multi_pulse_sync_rx: per-channel toggle synchroniser, pulse generator and saturating pending counter
// Define MULTI_PULSE_SYNC_OVF_STATUS_EN to add sticky overflow flags (ovf_o / ovf_clr_i).
module multi_pulse_sync_rx #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       toggle_i,
  input  logic [CHANNELS-1:0]       ready_i,
  output logic [CHANNELS-1:0]       pulse_o,
  output logic [CHANNELS-1:0]       valid_o,
  output logic [CHANNELS*CNT_W-1:0] pending_o
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
  ,
  output logic [CHANNELS-1:0]       ovf_o,
  input  logic [CHANNELS-1:0]       ovf_clr_i
`endif
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   pulse;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   pop;
    logic                   full;
    always_comb begin
      full    = &cnt;
      pop     = (cnt != '0) & ready_i[c];
      // a simultaneous increment and pop cancel, even when saturated
      cnt_nxt = (pulse & ~pop & ~full) ? cnt + 1'b1 :
                (pop & ~pulse)         ? cnt - 1'b1 : cnt;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync  <= '0;
        hist  <= 1'b0;
        pulse <= 1'b0;
        cnt   <= '0;
      end else begin
        sync  <= {sync[SYNC_STAGES-2:0], toggle_i[c]};
        hist  <= sync[SYNC_STAGES-1];
        pulse <= sync[SYNC_STAGES-1] ^ hist;
        cnt   <= cnt_nxt;
      end
    end
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
    logic ovf;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ovf <= 1'b0;
      else       ovf <= (pulse & ~pop & full) ? 1'b1 : ovf_clr_i[c] ? 1'b0 : ovf;
    end
    assign ovf_o[c] = ovf;
`endif
    assign pulse_o[c]                  = pulse;
    assign valid_o[c]                  = cnt != '0;
    assign pending_o[c*CNT_W +: CNT_W] = cnt;
  end
endmodule

// File: tb/tb_multi_pulse_sync_rx.sv
// tb_multi_pulse_sync_rx: directed + randomized bench against an event-timeline reference model
module tb_multi_pulse_sync_rx;
  localparam int CH = 4, SS = 2, W = 4, MAXC = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] toggle = '0, ready = '0;
  logic [CH-1:0] pulse_o, valid_o;
  logic [CH*W-1:0] pending_o;
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
  logic [CH-1:0] ovf_o, ovf_clr = '0;
  bit ovf_m [CH];
`endif
  int n_chk = 0, n_pass = 0, cyc = 0;
  int cnt_m [CH];
  bit pul_m [CH], last_m [CH];
  bit [CH-1:0] due_at [0:4095];
  int hold [CH];

  multi_pulse_sync_rx #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .toggle_i(toggle), .ready_i(ready),
    .pulse_o(pulse_o), .valid_o(valid_o), .pending_o(pending_o)
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
    , .ovf_o(ovf_o), .ovf_clr_i(ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model: a sampled level change is an event that surfaces as a pulse SS edges later,
  // and each pulse is counted one edge after it appears
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        cnt_m[c] = 0; pul_m[c] = 0; last_m[c] = 0;
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
        ovf_m[c] = 0;
`endif
      end
      for (int k = 0; k <= SS + 1; k++) due_at[cyc + k] = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit pop, evt;
        pop = cnt_m[c] > 0 && ready[c];
        evt = pul_m[c] && !pop && cnt_m[c] == MAXC;
        if (pul_m[c] && !pop && cnt_m[c] < MAXC) cnt_m[c]++;
        else if (pop && !pul_m[c]) cnt_m[c]--;
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
        if (evt) ovf_m[c] = 1;
        else if (ovf_clr[c]) ovf_m[c] = 0;
`endif
        pul_m[c] = due_at[cyc][c];
        if (toggle[c] != last_m[c]) begin
          due_at[cyc + SS][c] = 1'b1;
          last_m[c] = toggle[c];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      check($sformatf("pulse%0d", c), 32'(pulse_o[c]), 32'(pul_m[c]));
      check($sformatf("pend%0d", c), 32'(pending_o[c*W +: W]), 32'(cnt_m[c]));
      check($sformatf("valid%0d", c), 32'(valid_o[c]), 32'(cnt_m[c] != 0));
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
      check($sformatf("ovf%0d", c), 32'(ovf_o[c]), 32'(ovf_m[c]));
`endif
    end
  end

  initial begin
    cycles(3);
    check("rst_pend", 32'(pending_o), 0);
    check("rst_pulse", 32'(pulse_o), 0);
    rst = 1'b0;
    cycles(2);
    // single event latency on channel 0
    toggle[0] = 1'b1;
    cycles(2);
    check("t1_early", 32'(pulse_o), 0);
    cycles(1);
    check("t1_pulse", 32'(pulse_o), 32'h1);
    cycles(1);
    check("t1_pulse_off", 32'(pulse_o), 0);
    check("t1_pend", 32'(pending_o), 32'h0001);
    check("t1_valid", 32'(valid_o), 32'h1);
    // accumulate five events then drain back-to-back
    for (int i = 0; i < 5; i++) begin toggle[1] = ~toggle[1]; cycles(4); end
    cycles(2);
    check("t2_pend", 32'(pending_o[7:4]), 5);
    ready[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycles(1);
      check("t2_drain", 32'(pending_o[7:4]), 32'(5 - i));
    end
    check("t2_valid", 32'(valid_o[1]), 0);
    ready[1] = 1'b0;
    // saturation on channel 2
    for (int i = 0; i < 17; i++) begin toggle[2] = ~toggle[2]; cycles(4); end
    cycles(2);
    check("t3_sat", 32'(pending_o[11:8]), MAXC);
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
    check("t3_ovf", 32'(ovf_o[2]), 1);
    ovf_clr[2] = 1'b1;
    cycles(1);
    ovf_clr[2] = 1'b0;
    check("t3_ovf_clr", 32'(ovf_o[2]), 0);
`endif
    // channel 3 at max, increment and pop on the same edge
    for (int i = 0; i < 15; i++) begin toggle[3] = ~toggle[3]; cycles(4); end
    cycles(2);
    toggle[3] = ~toggle[3];
    cycles(3);
    ready[3] = 1'b1;
    cycles(1);
    ready[3] = 1'b0;
    check("t4_pend", 32'(pending_o[15:12]), MAXC);
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
    check("t4_ovf", 32'(ovf_o[3]), 0);
`endif
    // build counts 3/7/0/15 then reset between edges
    ready[2] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 2) toggle[0] = ~toggle[0];
      toggle[1] = ~toggle[1];
      cycles(4);
    end
    cycles(2);
    ready[2] = 1'b0;
    cycles(1);
    check("t5_pre", 32'(pending_o), 32'hF073);
    #2 rst = 1'b1;
    #1;
    check("t5_async_pend", 32'(pending_o), 0);
    check("t5_async_valid", 32'(valid_o), 0);
    check("t5_async_pulse", 32'(pulse_o), 0);
    toggle = '1;
    cycles(2);
    rst = 1'b0;
    cycles(8);
    check("t5_one_each", 32'(pending_o), 32'h1111);
    ready = '1;
    cycles(2);
    ready = '0;
    // double flip between two edges on channel 0
    #1 toggle[0] = ~toggle[0];
    #1 toggle[0] = ~toggle[0];
    cycles(6);
    check("t6_le1", 32'(pending_o[3:0] <= 1), 1);
    check("t6_noX", 32'(^{pulse_o, valid_o, pending_o} !== 1'bx), 1);
    // randomized traffic obeying the source spacing rule
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        hold[c]++;
        if (hold[c] >= SS + 1 && $urandom_range(3) == 0) begin
          toggle[c] = ~toggle[c];
          hold[c] = 0;
        end
        ready[c] = ($urandom_range(3) == 0);
`ifdef MULTI_PULSE_SYNC_OVF_STATUS_EN
        ovf_clr[c] = ($urandom_range(15) == 0);
`endif
      end
    end
    ready = '0;
    cycles(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multi_pulse_sync_rx.md
Name: multi_pulse_sync_rx

Overview:
- Receive side of a multi-channel pulse crossing into the clk_i domain.
- Each channel takes an asynchronous toggle level from a foreign domain. A toggle is one flip per event, as produced by the existing source-side toggle flop.
- Each channel synchronises the toggle through a parametrised flop chain and converts every level change into a single-cycle pulse.
- Pulses are accumulated in a per-channel saturating pending counter that is drained by a valid/ready handshake, so slow consumers lose no events.

Parameters:
- CHANNELS, 4: number of independent toggle channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- CNT_W, 4: pending-counter width per channel. Maximum pending count is 2^CNT_W-1.

Ports:
- clk_i  input  1  destination clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- toggle_i  input  CHANNELS  asynchronous toggle levels, one per channel.
- ready_i  input  CHANNELS  consumer accepts one event on channel c.
- pulse_o  output  CHANNELS  registered one-cycle pulse per detected toggle edge.
- valid_o  output  CHANNELS  channel c has >=1 pending event.
- pending_o  output  CHANNELS*CNT_W  pending counts; channel c is in bits [c*CNT_W +: CNT_W].
- ovf_o  output  CHANNELS  sticky overflow flags (present only with the optional feature).
- ovf_clr_i  input  CHANNELS  overflow clear (present only with the optional feature).

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk_i; reset rst_i is asynchronous and active-high.
  - While rst_i=1, all sync stages, edge-history flops, pulse_o, counters, valid_o and ovf_o are 0.
  - Release is sampled synchronously to clk_i by the system reset block.
- Synchroniser:
  - sync[0] captures toggle_i[c]; sync[k] captures sync[k-1].
  - hist captures sync[SYNC_STAGES-1].
  - edge = sync[last] ^ hist.
- Latency:
  - A toggle change that meets setup before rising edge E sets sync[0] at E.
  - pulse_o[c]=1 for exactly one cycle, registered at edge E+SYNC_STAGES.
  - The counter increments at edge E+SYNC_STAGES+1.
  - valid_o is combinational (count!=0), so it is high after edge E+SYNC_STAGES+1.
- Source spacing rule:
  - Each toggle level must be held >= SYNC_STAGES+1 clk_i periods.
  - Two toggles closer than that may cancel, losing both events. This is a documented source-side requirement, not detected by the block.
- Toggle asserted during reset:
  - Sync flops clear to 0, so a channel whose toggle_i is 1 at reset release yields exactly one event.
  - Sources must reset their toggle flops to 0 together with this block.
- Counter update per channel per edge, with inc = registered pulse and pop = valid_o & ready_i:
  - inc only, count < max: count+1.
  - inc only, count == max: count stays at max; overflow event.
  - pop only: count-1.
  - inc and pop together: count unchanged, including at max; not an overflow.
  - ready_i while count==0: ignored; no underflow.
- Channels are fully independent; no arbitration or shared state.
- Reset mid-operation: pending counts and in-flight sync state are discarded; outputs return to 0 asynchronously.

Optional Feature:
- Macro: MULTI_PULSE_SYNC_OVF_STATUS_EN.
- Defined:
  - ovf_o and ovf_clr_i exist.
  - ovf_o[c] is set at the edge where an overflow event occurs and holds until ovf_clr_i[c]=1 at a rising edge.
  - Set and clear in the same cycle: set wins.
  - Reset value is 0.
- Undefined:
  - Both ports are absent.
  - Overflow events are silently dropped; counter saturation behaviour is identical.

Test Plan:
1. Reset release, toggle_i[0] 0->1 once, ready_i=0 → pulse_o[0] high 1 cycle at edge E+2 (SYNC_STAGES=2); pending ch0 =1 and valid_o[0]=1 after E+3; other channels stay 0.
2. Ch1: 5 toggles spaced 4 cycles, ready_i=0, then ready_i[1]=1 held → pending reaches 5, then drains 5,4,3,2,1,0 over 5 consecutive edges; valid_o[1] falls after the 5th pop.
3. Ch2: 17 toggles with CNT_W=4, ready_i=0 → pending saturates at 15; with the macro, ovf_o[2]=1 after the 16th increment attempt; ovf_clr_i[2] pulse → 0.
4. Ch3 at count 15 with ready_i[3]=1 on the same edge as an increment → count stays 15; ovf_o[3] stays 0.
5. rst_i asserted asynchronously between clock edges with counts 3/7/0/15 → all outputs 0 immediately; after release with all toggle_i=1 → each channel reports exactly one event.
6. toggle_i[0] flipped twice within 1 cycle → at most one pulse or none; the counter never exceeds 1 and no X appears on any output.
